// File: rtl/dmem_pkg.sv
// Shared types for the MEM-stage data memory: access length, fault codes, FSM states.
package dmem_pkg;

  typedef enum logic [1:0] {
    LEN_WORD  = 2'b00,
    LEN_BYTE  = 2'b01,
    LEN_HALF  = 2'b10,
    LEN_WORD2 = 2'b11
  } length_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10
  } err_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  function automatic logic [2:0] len_bytes(input length_e len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised RAM with four byte lanes: byte-enabled synchronous write, registered read.
module dmem_byte_ram
  import dmem_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int WA    = 10
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [WA-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/lsu_datamem.sv
// Clocked data memory for the MEM stage: valid/ready request, fixed-latency response,
// little-endian byte/half/word access with sign/zero extension and fault reporting.
module lsu_datamem
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 4096,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_length,
  input  logic              req_sign,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int WA    = $clog2(WORDS);
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH_BYTES);

  function automatic err_e fault_of(input logic [ADDR_W-1:0] a, input length_e len);
    logic [ADDR_W:0] end_x;
    end_x = {1'b0, a} + (ADDR_W + 1)'(len_bytes(len));
    if ((len == LEN_HALF && a[0]) ||
        ((len == LEN_WORD || len == LEN_WORD2) && a[1:0] != 2'b00)) return ERR_MISALIGN;
    if (end_x > DEPTH_X) return ERR_RANGE;
    return ERR_OK;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] lane,
                                              input length_e len, input logic sgn);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = w >> {lane, 3'b000};
    b  = signed'(sh[7:0]);
    h  = signed'(sh[15:0]);
    case (len)
      LEN_BYTE: return sgn ? 32'(b) : {24'b0, sh[7:0]};
      LEN_HALF: return sgn ? 32'(h) : {16'b0, sh[15:0]};
      default:  return w;
    endcase
  endfunction

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept, enter_resp;

  logic              write_p0, sign_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [31:0]       wdata_p0;
  length_e           len_p0;

  logic              op_write, op_sign;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_wdata;
  length_e           op_len;
  err_e              op_err;
  logic [3:0]        be;
  logic [31:0]       wlane;
  logic [3:0]        ram_we;
  logic [31:0]       ram_q;

  logic              kill_p1, sign_p1;
  logic [1:0]        lane_p1;
  length_e           len_p1;
  err_e              err_p1;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      kill_p1 <= 1'b1;
      err_p1  <= ERR_OK;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (enter_resp) begin
        kill_p1 <= op_write || (op_err != ERR_OK);
        err_p1  <= op_err;
      end
    end
  end

  // p0: request capture on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p0 <= req_write;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
      len_p0   <= length_e'(req_length);
      sign_p0  <= req_sign;
    end
  end

  // With zero wait states the edge that accepts also commits, so the live request is used.
  always_comb begin
    if (state == IDLE) begin
      op_write = req_write;
      op_addr  = req_addr;
      op_wdata = req_wdata;
      op_len   = length_e'(req_length);
      op_sign  = req_sign;
    end else begin
      op_write = write_p0;
      op_addr  = addr_p0;
      op_wdata = wdata_p0;
      op_len   = len_p0;
      op_sign  = sign_p0;
    end
    op_err = fault_of(op_addr, op_len);
    be     = 4'b1111;
    wlane  = op_wdata;
    case (op_len)
      LEN_BYTE: begin
        be    = 4'b0001 << op_addr[1:0];
        wlane = {4{op_wdata[7:0]}};
      end
      LEN_HALF: begin
        be    = op_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{op_wdata[15:0]}};
      end
      default: ;
    endcase
    ram_we = (enter_resp && op_write && op_err == ERR_OK) ? be : 4'b0000;
  end

  dmem_byte_ram #(
    .WORDS (WORDS),
    .WA    (WA)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (enter_resp),
    .addr  (op_addr[WA+1:2]),
    .wdata (wlane),
    .rdata (ram_q)
  );

  // p1: response shaping, held until the next response
  always_ff @(posedge clk) begin
    if (enter_resp) begin
      lane_p1 <= op_addr[1:0];
      len_p1  <= op_len;
      sign_p1 <= op_sign;
    end
  end

  assign resp_rdata = kill_p1 ? 32'h0 : load_extend(ram_q, lane_p1, len_p1, sign_p1);
  assign resp_err   = err_p1;

endmodule

// File: tb/tb_lsu_datamem.sv
// Directed bench for lsu_datamem: scoreboard of expected responses, plus accept-spacing
// checks on zero and three wait-state instances.
module tb_lsu_datamem;

  localparam int DEPTH = 4096;

  typedef struct {
    logic [31:0] rd;
    logic [1:0]  er;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset;
  logic        req_write, req_sign;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_length;

  logic        v1, rdy1, rv1;
  logic [31:0] rd1;
  logic [1:0]  er1;
  logic        v0, rdy0, rv0;
  logic [31:0] rd0;
  logic [1:0]  er0;
  logic        v3, rdy3, rv3;
  logic [31:0] rd3;
  logic [1:0]  er3;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  lsu_datamem #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .WAIT_STATES(1)) u1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_length(req_length), .req_sign(req_sign),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(er1));

  lsu_datamem #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_length(req_length), .req_sign(req_sign),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0));

  lsu_datamem #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .WAIT_STATES(3)) u3 (
    .clk(clk), .reset(reset), .req_valid(v3), .req_ready(rdy3), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_length(req_length), .req_sign(req_sign),
    .resp_valid(rv3), .resp_rdata(rd3), .resp_err(er3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on the WAIT_STATES=1 instance, checked against the scoreboard.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] len, input logic sg, input logic [31:0] erd,
                      input logic [1:0] eer);
    int   t_drv;
    bit   got;
    exp_t e;
    got = 1'b0;
    @(negedge clk);
    req_write = wr; req_addr = a; req_wdata = wd; req_length = len; req_sign = sg; v1 = 1'b1;
    t_drv = cyc;
    chk({tag, "_ready"}, {31'b0, rdy1}, 32'd1);
    sb_q.push_back('{erd, eer});
    @(negedge clk);
    v1 = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (rv1) got = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_seen"}, {31'b0, got}, 32'd1);
    if (got) begin
      e = sb_q.pop_front();
      chk({tag, "_lat"}, 32'(cyc - t_drv), 32'd2);
      chk({tag, "_rdata"}, rd1, e.rd);
      chk({tag, "_err"}, {30'b0, er1}, {30'b0, e.er});
      @(negedge clk);
      chk({tag, "_pulse"}, {31'b0, rv1}, 32'd0);
      chk({tag, "_hold"}, rd1, e.rd);
    end else begin
      void'(sb_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int rv_cnt;
    int acc0[$], acc3[$], rsp3[$];

    reset = 1'b1; v1 = 1'b0; v0 = 1'b0; v3 = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0; req_length = 2'b00; req_sign = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, rdy1}, 32'd1);
    chk("rst_valid", {31'b0, rv1}, 32'd0);
    chk("rst_rdata", rd1, 32'h0);
    chk("rst_err", {30'b0, er1}, 32'd0);
    chk("rst_ready0", {31'b0, rdy0}, 32'd1);
    chk("rst_ready3", {31'b0, rdy3}, 32'd1);
    reset = 1'b0;

    xfer("st_word", 1, 32'h10, 32'hDEADBEEF, 2'b00, 0, 32'h0, 2'b00);
    xfer("ld_word", 0, 32'h10, 32'h0, 2'b00, 0, 32'hDEADBEEF, 2'b00);
    xfer("ld_b13s", 0, 32'h13, 32'h0, 2'b01, 1, 32'hFFFFFFDE, 2'b00);
    xfer("ld_b13u", 0, 32'h13, 32'h0, 2'b01, 0, 32'h000000DE, 2'b00);
    xfer("ld_b10s", 0, 32'h10, 32'h0, 2'b01, 1, 32'hFFFFFFEF, 2'b00);
    xfer("ld_h10s", 0, 32'h10, 32'h0, 2'b10, 1, 32'hFFFFBEEF, 2'b00);
    xfer("ld_h12u", 0, 32'h12, 32'h0, 2'b10, 0, 32'h0000DEAD, 2'b00);
    xfer("ld_w11",  0, 32'h10, 32'h0, 2'b11, 0, 32'hDEADBEEF, 2'b00);

    xfer("st_b11", 1, 32'h11, 32'hFFFFFF5A, 2'b01, 0, 32'h0, 2'b00);
    xfer("ld_merge", 0, 32'h10, 32'h0, 2'b00, 0, 32'hDEAD5AEF, 2'b00);

    xfer("st_h13", 1, 32'h13, 32'h00001111, 2'b10, 0, 32'h0, 2'b01);
    xfer("ld_unch", 0, 32'h10, 32'h0, 2'b00, 0, 32'hDEAD5AEF, 2'b00);
    xfer("st_top", 1, DEPTH - 4, 32'h80FF1234, 2'b00, 0, 32'h0, 2'b00);
    xfer("ld_htop", 0, DEPTH - 2, 32'h0, 2'b10, 1, 32'hFFFF80FF, 2'b00);
    xfer("ld_btop", 0, DEPTH - 1, 32'h0, 2'b01, 0, 32'h00000080, 2'b00);
    xfer("ld_wmis", 0, DEPTH - 2, 32'h0, 2'b00, 0, 32'h0, 2'b01);
    xfer("ld_wrng", 0, DEPTH, 32'h0, 2'b00, 0, 32'h0, 2'b10);
    xfer("ld_brng", 0, DEPTH, 32'h0, 2'b01, 1, 32'h0, 2'b10);
    xfer("ld_wrap", 0, 32'hFFFFFFFC, 32'h0, 2'b00, 0, 32'h0, 2'b10);
    xfer("ld_prio", 0, DEPTH + 1, 32'h0, 2'b10, 0, 32'h0, 2'b01);
    xfer("st_wrng", 1, DEPTH, 32'hAAAAAAAA, 2'b00, 0, 32'h0, 2'b10);

    xfer("st_20", 1, 32'h20, 32'hCAFEF00D, 2'b00, 0, 32'h0, 2'b00);
    xfer("ld_20a", 0, 32'h20, 32'h0, 2'b00, 0, 32'hCAFEF00D, 2'b00);
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_length = 2'b00; v1 = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1; v1 = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    rv_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rv1) rv_cnt++;
    end
    chk("abort_noresp", 32'(rv_cnt), 32'd0);
    chk("abort_ready", {31'b0, rdy1}, 32'd1);
    chk("abort_rdata", rd1, 32'h0);
    chk("abort_err", {30'b0, er1}, 32'd0);
    xfer("ld_20b", 0, 32'h20, 32'h0, 2'b00, 0, 32'hCAFEF00D, 2'b00);

    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h0; req_length = 2'b00; req_sign = 1'b0;
    v0 = 1'b1; v3 = 1'b1;
    for (int k = 0; k < 26; k++) begin
      if (rdy0) acc0.push_back(cyc);
      if (rdy3) acc3.push_back(cyc);
      if (rv3) rsp3.push_back(cyc);
      @(negedge clk);
    end
    v0 = 1'b0; v3 = 1'b0;
    chk("w0_count", 32'(acc0.size()), 32'd13);
    for (int i = 1; i < acc0.size(); i++) chk("w0_space", 32'(acc0[i] - acc0[i-1]), 32'd2);
    chk("w3_count", 32'(acc3.size()), 32'd6);
    for (int i = 1; i < acc3.size(); i++) chk("w3_space", 32'(acc3[i] - acc3[i-1]), 32'd5);
    chk("w3_rspn", {31'b0, (rsp3.size() > 0 && acc3.size() > 0)}, 32'd1);
    if (rsp3.size() > 0 && acc3.size() > 0) chk("w3_lat", 32'(rsp3[0] - acc3[0]), 32'd4);
    chk("w3_rdata", rd3, 32'h0);
    chk("w3_err", {30'b0, er3}, 32'd0);
    chk("w0_err", {30'b0, er0}, 32'd0);
    chk("w0_rdata", rd0, 32'h0);
    chk("w0_idle", {31'b0, rv0}, {31'b0, rv0 & ~rdy0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
